// File: rtl/key_sel_pkg.sv
// Shared constants for the AES key/path selector: IP indices, arbiter FSM states, default sizing.
package key_sel_pkg;

    localparam int DEF_NUM_IP = 3;
    localparam int DEF_IDX_W  = 2;

    // IP indices; must stay aligned with the key selector's ipN_in ordering
    localparam logic [1:0] AES0 = 2'h0;
    localparam logic [1:0] AES1 = 2'h1;
    localparam logic [1:0] AES2 = 2'h2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACTIVE = 2'd2
    } state_e;

endpackage

// File: rtl/key_sel_rr_pick.sv
// Combinational round-robin picker: first set req searching upward from last_grant+1 with wrap.
// Zero latency; any=0 when no request is present.
module key_sel_rr_pick
    import key_sel_pkg::*;
#(
    parameter int NUM_IP = DEF_NUM_IP,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic [NUM_IP-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [IDX_W-1:0]  grant,
    output logic              any
);

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        any   = 1'b0;
        for (int k = 1; k <= NUM_IP; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_IP) idx = idx - NUM_IP;
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/key_sel_arbiter.sv
// Round-robin lock of the shared AES port: req in IDLE -> ip_sel_o pulse next cycle -> path_open_o SETTLE_CYC later.
// addr_stall_o blocks new addresses at MAX_OUT outstanding; KEY_SEL_TIMEOUT_EN adds a no-progress watchdog.
module key_sel_arbiter
    import key_sel_pkg::*;
#(
    parameter int NUM_IP      = DEF_NUM_IP,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int MAX_OUT     = 4,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IP-1:0] ip_aw_valid,
    input  logic [NUM_IP-1:0] ip_ar_valid,
    input  logic              fab_addr_hs,
    input  logic              fab_done,
    output logic [NUM_IP-1:0] ip_sel_o,
    output logic [IDX_W-1:0]  grant_idx_o,
    output logic              path_open_o,
    output logic              addr_stall_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] OUT_MAX  = CNT_W'(MAX_OUT);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

    if (SETTLE_CYC < 1 || MAX_OUT < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("key_sel_arbiter: SETTLE_CYC, MAX_OUT and TIMEOUT_CYC must be >= 1");
    end

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [NUM_IP-1:0] sel_q, sel_d;
    logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [NUM_IP-1:0] req;
    logic [IDX_W-1:0]  pick_grant;
    logic              pick_any;
    logic              inc_ok, dec_ok;

    assign req    = ip_aw_valid | ip_ar_valid;
    // Over-issue at MAX_OUT and completions with nothing outstanding are dropped, not wrapped
    assign inc_ok = fab_addr_hs && (out_q != OUT_MAX);
    assign dec_ok = fab_done && (out_q != '0);

    key_sel_rr_pick #(
        .NUM_IP (NUM_IP),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .any        (pick_any)
    );

`ifdef KEY_SEL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYC);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        sel_d        = '0;
        set_cnt_d    = set_cnt_q;
        out_d        = out_q;
`ifdef KEY_SEL_TIMEOUT_EN
        wd_d         = '0;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d           = pick_grant;
                    sel_d[pick_grant] = 1'b1;
                    set_cnt_d         = '0;
                    state_d           = SETTLE;
                end
            end
            SETTLE: begin
                if (set_cnt_q == SET_LAST) state_d = ACTIVE;
                else set_cnt_d = set_cnt_q + SET_W'(1);
            end
            ACTIVE: begin
                if (inc_ok && !dec_ok) out_d = out_q + CNT_W'(1);
                else if (dec_ok && !inc_ok) out_d = out_q - CNT_W'(1);
                if (!req[grant_q] && out_d == '0) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
`ifdef KEY_SEL_TIMEOUT_EN
                else begin
                    wd_d = (fab_addr_hs || fab_done) ? '0 : wd_q + WD_W'(1);
                    if (wd_d == WD_LIM) begin
                        timeout_d    = 1'b1;
                        out_d        = '0;
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_IP - 1);
            sel_q        <= '0;
            set_cnt_q    <= '0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            set_cnt_q    <= set_cnt_d;
            out_q        <= out_d;
        end
    end

`ifdef KEY_SEL_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign ip_sel_o     = sel_q;
    assign path_open_o  = (state_q == ACTIVE);
    assign grant_idx_o  = path_open_o ? grant_q : '0;
    assign addr_stall_o = (out_q == OUT_MAX);
    assign busy_o       = (state_q != IDLE);

endmodule
